// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signals of the data cache, bundled for one port.
// Signal suffixes are named from the cache's point of view.
interface dcache_ctrl_if;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    modport slave (
        input  addr_i, wdata_i, MemRead_i, MemWrite_i, mem_rdata_i, mem_ack_i,
        output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               hit_cnt_o, miss_cnt_o
    );

    modport master (
        output addr_i, wdata_i, MemRead_i, MemWrite_i, mem_rdata_i, mem_ack_i,
        input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline while lines are written back / refilled over req/ack.
module dcache_ctrl #(
    parameter int IDX_W  = 5,
    parameter int LINE_W = 128
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);

    localparam int TAG_W  = 32 - 4 - IDX_W;
    localparam int NLINES = 1 << IDX_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]       hit_cnt_q, miss_cnt_q;
    logic              refill_q;

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        word;
    logic              access;
    logic              hit;
    logic              fillEn;
    logic              storeEn;
    logic              countEn;
    logic [LINE_W-1:0] curLine;
    logic              unusedAddrBits;

    assign tag            = bus.addr_i[31:4+IDX_W];
    assign idx            = bus.addr_i[3+IDX_W:4];
    assign word           = bus.addr_i[3:2];
    assign unusedAddrBits = ^bus.addr_i[1:0];

    assign access  = bus.MemRead_i | bus.MemWrite_i;
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign curLine = data_q[idx];
    assign fillEn  = (state_q == ALLOCATE) && bus.mem_ack_i;
    assign storeEn = (state_q == IDLE) && access && hit && bus.MemWrite_i;
    // The lookup right after a refill is the held access retrying, not a new one.
    assign countEn = (state_q == IDLE) && access && !refill_q;

    assign bus.stall_o     = (state_q != IDLE) || (access && !hit);
    assign bus.rdata_o     = bus.MemRead_i ? curLine[{word, 5'b0} +: 32] : 32'd0;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.hit_cnt_o   = hit_cnt_q;
    assign bus.miss_cnt_o  = miss_cnt_q;

    // Memory-side outputs are computed one step ahead so they leave the block registered.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, 4'b0};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, 4'b0};
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack_i) begin
                    state_d    = ALLOCATE;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag, idx, 4'b0};
                end
            end
            ALLOCATE: begin
                if (bus.mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
            refill_q    <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            refill_q    <= fillEn;
            if (countEn && hit) begin
                hit_cnt_q <= hit_cnt_q + {31'd0, ~&hit_cnt_q};
            end
            if (countEn && !hit) begin
                miss_cnt_q <= miss_cnt_q + {31'd0, ~&miss_cnt_q};
            end
            if (fillEn) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (storeEn) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits make stale contents harmless.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fillEn) begin
            data_q[idx] <= bus.mem_rdata_i;
            tag_q[idx]  <= tag;
        end else if (!rst_i && storeEn) begin
            data_q[idx][{word, 5'b0} +: 32] <= bus.wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl: a line-level cache model predicts
// load data, counters, stall length and memory transactions; monitors compare.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();

    dcache_ctrl #(.IDX_W(5), .LINE_W(128)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } memTxn_t;

    int checks   = 0;
    int failures = 0;

    memTxn_t     memExpQ[$];
    logic [31:0] rdExpQ[$];

    logic [127:0] refMem [logic [31:0]];
    logic [127:0] extMem [logic [31:0]];

    bit           mValid    [32];
    bit           mDirty    [32];
    logic [27:0]  mLineAddr [32];
    logic [127:0] mLine     [32];
    int           hitCnt;
    int           missCnt;

    int ackLat    = 3;
    int spurReqs  = 0;
    int spurDone  = 0;

    function automatic logic [127:0] pattern(input logic [31:0] la);
        return {la ^ 32'h3C3C0003, la ^ 32'h5A5A0002, la ^ 32'hA5A50001, la ^ 32'hC3C30000};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
        hitCnt  = 0;
        missCnt = 0;
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int          idx;
        int          w;
        int          expStall;
        int          stallCnt;
        logic [27:0] la;
        memTxn_t     t;
        idx = int'(addr[8:4]);
        w   = int'(addr[3:2]);
        la  = addr[31:4];
        if (mValid[idx] && mLineAddr[idx] == la) begin
            hitCnt++;
            expStall = 0;
        end else begin
            missCnt++;
            expStall = 1 + ackLat;
            if (mValid[idx] && mDirty[idx]) begin
                t.we    = 1'b1;
                t.addr  = {mLineAddr[idx], 4'b0};
                t.wdata = mLine[idx];
                memExpQ.push_back(t);
                refMem[{mLineAddr[idx], 4'b0}] = mLine[idx];
                expStall += ackLat;
            end
            t.we    = 1'b0;
            t.addr  = {la, 4'b0};
            t.wdata = '0;
            memExpQ.push_back(t);
            mLine[idx]     = refMem.exists({la, 4'b0}) ? refMem[{la, 4'b0}] : pattern({la, 4'b0});
            mValid[idx]    = 1'b1;
            mDirty[idx]    = 1'b0;
            mLineAddr[idx] = la;
        end
        if (rd) rdExpQ.push_back(mLine[idx][w*32 +: 32]);
        if (wr) begin
            mLine[idx][w*32 +: 32] = wd;
            mDirty[idx] = 1'b1;
        end
        bus.addr_i     = addr;
        bus.wdata_i    = wd;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        stallCnt = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall_o) break;
            stallCnt++;
            if (stallCnt > 100) break;
        end
        checkOutput("stallCycles", stallCnt, expStall);
        @(posedge clk); #1;
        checkOutput("hitCnt", bus.hit_cnt_o, hitCnt);
        checkOutput("missCnt", bus.miss_cnt_o, missCnt);
    endtask

    task automatic idleCycles(input int n);
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checkOutput("idleStall", bus.stall_o, 1'b0);
            checkOutput("idleReq", bus.mem_req_o, 1'b0);
            checkOutput("idleHitCnt", bus.hit_cnt_o, hitCnt);
            checkOutput("idleMissCnt", bus.miss_cnt_o, missCnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("rstStall", bus.stall_o, 1'b0);
        checkOutput("rstReq", bus.mem_req_o, 1'b0);
        checkOutput("rstWe", bus.mem_we_o, 1'b0);
        checkOutput("rstAddr", bus.mem_addr_o, 32'd0);
        checkOutput("rstWdata", bus.mem_wdata_o, 128'd0);
        checkOutput("rstHitCnt", bus.hit_cnt_o, 32'd0);
        checkOutput("rstMissCnt", bus.miss_cnt_o, 32'd0);
        checkOutput("rstRdata", bus.rdata_o, 32'd0);
        @(posedge clk); #1;
    endtask

    // Load-data monitor: an access completes on the edge after stall is seen low.
    always @(negedge clk) begin
        if (!rst && bus.MemRead_i && !bus.stall_o) begin
            if (rdExpQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rdataUnexpected actual=%h required=none", bus.rdata_o);
            end else begin
                checkOutput("rdata", bus.rdata_o, rdExpQ.pop_front());
            end
        end
    end

    // Off-chip memory: checks each request, holds it ackLat cycles, then acks.
    initial begin
        int      cnt;
        memTxn_t cur;
        memTxn_t exp;
        cnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                cnt++;
                if (cnt == 1) begin
                    cur.we    = bus.mem_we_o;
                    cur.addr  = bus.mem_addr_o;
                    cur.wdata = bus.mem_wdata_o;
                    if (memExpQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL memReqUnexpected actual=%h required=none", bus.mem_addr_o);
                    end else begin
                        exp = memExpQ.pop_front();
                        checkOutput("memWe", bus.mem_we_o, exp.we);
                        checkOutput("memAddr", bus.mem_addr_o, exp.addr);
                        if (exp.we) checkOutput("memWdata", bus.mem_wdata_o, exp.wdata);
                    end
                end else begin
                    checkOutput("memStableAddr", bus.mem_addr_o, cur.addr);
                    checkOutput("memStableWe", bus.mem_we_o, cur.we);
                end
                if (cnt >= ackLat) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_we_o) extMem[bus.mem_addr_o] = bus.mem_wdata_o;
                    else bus.mem_rdata_i = extMem.exists(bus.mem_addr_o) ? extMem[bus.mem_addr_o]
                                                                       : pattern(bus.mem_addr_o);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (spurReqs > spurDone) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                    spurDone++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          kind;
        int          idxSel;
        logic [31:0] a;
        rst            = 1'b1;
        bus.addr_i     = 32'd0;
        bus.wdata_i    = 32'd0;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        modelReset();
        @(posedge clk); #1;
        resetDut();

        refMem[32'h100] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        extMem[32'h100] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        ackLat = 3;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'd0);
        checkOutput("planMissCnt", bus.miss_cnt_o, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h104, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h104, 32'd0);
        checkOutput("planHitCnt", bus.hit_cnt_o, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'd0);
        idleCycles(3);

        spurReqs++;
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'd0);

        for (int i = 0; i < 300; i++) begin
            kind   = int'($urandom_range(0, 9));
            idxSel = int'($urandom_range(0, 4));
            a = ($urandom_range(0, 3) << 9) | ((idxSel == 4 ? 32'd31 : 32'(idxSel)) << 4)
                | ($urandom_range(0, 3) << 2);
            ackLat = int'($urandom_range(1, 4));
            if (kind == 0)      idleCycles(1);
            else if (kind <= 4) applyStimulus(1'b1, 1'b0, a, $urandom);
            else if (kind <= 8) applyStimulus(1'b0, 1'b1, a, $urandom);
            else                applyStimulus(1'b1, 1'b1, a, $urandom);
        end

        // Reset while a refill is outstanding: the request must vanish and the line stay invalid.
        resetDut();
        ackLat = 20;
        memExpQ.push_back('{we: 1'b0, addr: 32'h7A0, wdata: 128'd0});
        bus.addr_i    = 32'h7A0;
        bus.MemRead_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstTestStall", bus.stall_o, 1'b1);
        end
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.MemRead_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        checkOutput("abortReq", bus.mem_req_o, 1'b0);
        checkOutput("abortStall", bus.stall_o, 1'b0);
        ackLat = 2;
        applyStimulus(1'b1, 1'b0, 32'h7A0, 32'd0);
        checkOutput("abortReMiss", bus.miss_cnt_o, 32'd1);

        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        @(negedge clk);
        checkOutput("memQueueDrained", memExpQ.size(), 0);
        checkOutput("rdQueueDrained", rdExpQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
